// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern recogniser.
// Matches a 1..PAT_W-bit pattern on a qualified serial stream. Detection can be
// overlapping or non-overlapping, and a saturating counter tallies the matches.
module seq_pattern_detector #(
   parameter int unsigned          PAT_W   = 4,
   parameter int unsigned          CNT_W   = 8,
   parameter logic [PAT_W-1:0]     DEF_PAT = 4'b1101,
   parameter int unsigned          DEF_LEN = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         din_valid,
   input  logic                         din,
   input  logic                         overlap,
   input  logic                         pat_load,
   input  logic [PAT_W-1:0]             pat_in,
   input  logic [$clog2(PAT_W+1)-1:0]   len_in,
   input  logic                         cnt_clr,
   output logic                         match,
   output logic [CNT_W-1:0]             match_count,
   output logic [$clog2(PAT_W+1)-1:0]   fill_lvl
);

   localparam int unsigned      LW        = $clog2(PAT_W + 1);
   localparam logic [LW-1:0]    FULL      = LW'(PAT_W);
   localparam logic [LW-1:0]    DEF_LEN_L = LW'(DEF_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   // Only the newest PAT_W-1 bits are stored: the oldest of PAT_W history bits
   // is shifted out before it can ever take part in a comparison.
   logic [PAT_W-2:0] hist_q, hist_d;
   logic [LW-1:0]    fill_q, fill_d;
   logic             match_q, match_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [LW-1:0]    len_q, len_d;

   logic [PAT_W-1:0] hist_nxt;
   logic [PAT_W-1:0] len_mask;
   logic [LW:0]      fill_inc;
   logic             accepted;
   logic             hit;

   // Compare the would-be history against the low len bits of the pattern.
   always_comb begin
      accepted = din_valid && !pat_load;
      hist_nxt = {hist_q, din};
      len_mask = '0;
      for (int unsigned i = 0; i < PAT_W; i++) begin
         if (i < 32'(len_q)) begin
            len_mask[i] = 1'b1;
         end
      end
      fill_inc = {1'b0, fill_q} + (LW+1)'(1);
      hit      = accepted
                 && (fill_inc >= {1'b0, len_q})
                 && (((hist_nxt ^ pat_q) & len_mask) == '0);
   end

   // Next-state: pattern load outranks bit acceptance; counter clear outranks a hit.
   always_comb begin
      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = 1'b0;
      cnt_d   = cnt_q;
      pat_d   = pat_q;
      len_d   = len_q;

      if (pat_load) begin
         pat_d  = pat_in;
         len_d  = ((len_in == '0) || (len_in > FULL)) ? FULL : len_in;
         hist_d = '0;
         fill_d = '0;
      end else if (accepted) begin
         hist_d  = hist_nxt[PAT_W-2:0];
         match_d = hit;
         if (hit && !overlap) begin
            fill_d = '0;
         end else if (fill_q != FULL) begin
            fill_d = fill_q + LW'(1);
         end
      end

      if (cnt_clr) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         cnt_q   <= '0;
         pat_q   <= DEF_PAT;
         len_q   <= DEF_LEN_L;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         cnt_q   <= cnt_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      match       = match_q;
      match_count = cnt_q;
      fill_lvl    = fill_q;
   end

endmodule
